hazard_pipe: RTL and testbench

Parametrised in-order instruction pipeline shell for the pipelined CPU. It carries an opaque instruction payload through STAGES elastic stages with valid/ready handshakes, flush, RAW-hazard interlock and performance counters. It replaces the hand-wired fixed pipeline registers between fetch/issue and writeback. It does not forward data; dependent instructions stall at issue until the producer retires.

---
 rtl/hazard_pipe.sv | 102 ++++++++++
 tb/tb_hazard_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_pipe.sv
// hazard_pipe: elastic in-order pipeline shell with RAW interlock, flush and perf counters
module hazard_pipe #(
  parameter int STAGES = 5,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic in_rd_we,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic in_rs1_use,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic in_rs2_use,
  input  logic flush,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic out_rd_we,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int OW = $clog2(STAGES+1);
  logic [STAGES-1:0] v_q, v_d, we_q, we_d, free;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [REG_AW-1:0] rd_q [STAGES];
  logic [REG_AW-1:0] rd_d [STAGES];
  logic [OW-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] ret_q, ret_d, stall_q, stall_d;
  logic f, hit, acc, fire;
  always_comb begin
    f = out_ready;
    free = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      f = f || !v_q[i];
      free[i] = f;
    end
    hit = 1'b0;
    for (int k = 0; k < STAGES; k++)
      hit = hit || (v_q[k] && we_q[k] &&
            ((in_rs1_use && in_rs1 != '0 && rd_q[k] == in_rs1) ||
             (in_rs2_use && in_rs2 != '0 && rd_q[k] == in_rs2)));
    in_ready = !reset && !flush && !hit && free[0];
    acc = in_valid && in_ready;
    fire = v_q[STAGES-1] && out_ready;
    v_d = v_q;
    we_d = we_q;
    data_d = data_q;
    rd_d = rd_q;
    for (int i = STAGES-1; i > 0; i--)
      if (free[i]) begin
        v_d[i] = v_q[i-1];
        we_d[i] = we_q[i-1];
        data_d[i] = data_q[i-1];
        rd_d[i] = rd_q[i-1];
      end
    if (free[0]) begin
      v_d[0] = acc;
      we_d[0] = in_rd_we;
      data_d[0] = in_data;
      rd_d[0] = in_rd;
    end
    if (flush) v_d = '0;
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) occ_d = occ_d + OW'(v_d[i]);
    ret_d = ret_q + CNT_W'(fire);
    stall_d = stall_q + CNT_W'(in_valid && !in_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      we_q <= '0;
      data_q <= '{default: '0};
      rd_q <= '{default: '0};
      occ_q <= '0;
      ret_q <= '0;
      stall_q <= '0;
    end else begin
      v_q <= v_d;
      we_q <= we_d;
      data_q <= data_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      ret_q <= ret_d;
      stall_q <= stall_d;
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign out_data = data_q[STAGES-1];
  assign out_rd = rd_q[STAGES-1];
  assign out_rd_we = we_q[STAGES-1];
  assign occupancy = occ_q;
  assign retire_cnt = ret_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe: scoreboard bench for hazard_pipe covering stream, hazards, backpressure, flush, reset and wrap
module tb_hazard_pipe;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, in_rd_we = 0, in_rs1_use = 0, in_rs2_use = 0, flush = 0;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0, out_rd;
  logic out_valid, out_ready = 0, out_rd_we;
  logic [2:0] occupancy;
  logic [3:0] retire_cnt, stall_cnt;
  typedef struct {logic [31:0] d; logic [4:0] rd; logic we; int cyc;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0, n_chk = 0, n_fail = 0, seq = 0, acc, c0;
  hazard_pipe #(.STAGES(5), .DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_rs1(in_rs1), .in_rs1_use(in_rs1_use),
    .in_rs2(in_rs2), .in_rs2_use(in_rs2_use), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .occupancy(occupancy), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
      else begin
        mon_e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_e.d));
        chk("out_rd", 64'(out_rd), 64'(mon_e.rd));
        chk("out_rd_we", 64'(out_rd_we), 64'(mon_e.we));
        if (mon_e.cyc >= 0) chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic we,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic keep, input logic timed, output int a);
    int n = 0;
    in_valid = 1; in_data = d; in_rd = rd; in_rd_we = we;
    in_rs1 = rs1; in_rs1_use = u1; in_rs2 = rs2; in_rs2_use = u2;
    a = -1;
    while (a < 0 && n < 60) begin
      @(negedge clk);
      if (in_ready) begin
        a = cyc;
        if (keep) q.push_back('{d, rd, we, timed ? cyc + 5 : -1});
      end
      tick(1);
      n++;
    end
    if (a < 0) chk("send_timeout", 64'(n), 64'(0));
    in_valid = 0; in_rs1_use = 0; in_rs2_use = 0;
  endtask
  task automatic haz(input string nm, input logic [4:0] rda, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input int dly);
    int a;
    c0 = cyc;
    send(32'hB000_0000 + 32'(seq++), rda, 1, 0, 0, 0, 0, 1, 1, a);
    send(32'hB000_0000 + 32'(seq++), 5'd7, 1, rs1, u1, rs2, u2, 1, 1, a);
    chk(nm, 64'(a), 64'(c0 + dly));
    tick(14);
  endtask
  initial begin
    tick(3);
    reset = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_rd", 64'(out_rd), 64'(0));
    chk("rst_out_rd_we", 64'(out_rd_we), 64'(0));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_retire", 64'(retire_cnt), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    tick(1);
    out_ready = 1;
    c0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      send(32'hA000 + 32'(i), 5'(i), 1, 0, 0, 0, 0, 1, 1, acc);
      chk("t1_acc", 64'(acc), 64'(c0 + i - 1));
    end
    tick(10);
    chk("t1_retire", 64'(retire_cnt), 64'(6));
    chk("t1_stall", 64'(stall_cnt), 64'(0));
    chk("t1_occ", 64'(occupancy), 64'(0));
    haz("haz_rs1_acc", 5'd3, 5'd3, 1, 0, 0, 6);
    haz("haz_rs2_acc", 5'd5, 0, 0, 5'd5, 1, 6);
    haz("haz_rd0_acc", 5'd0, 5'd0, 1, 0, 0, 1);
    haz("haz_nouse_acc", 5'd3, 5'd3, 0, 0, 0, 1);
    chk("t2_stall", 64'(stall_cnt), 64'(10));
    chk("t2_retire", 64'(retire_cnt), 64'(14));
    out_ready = 0;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      send(32'hD000 + 32'(k), 5'(8 + k), 1, 0, 0, 0, 0, 1, 0, acc);
      chk("t3_acc", 64'(acc), 64'(c0 + k));
    end
    in_valid = 1; in_data = 32'hD005; in_rd = 5'd13; in_rd_we = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t3_in_ready", 64'(in_ready), 64'(0));
      chk("t3_occ", 64'(occupancy), 64'(5));
      chk("t3_stall", 64'(stall_cnt), 64'(10 + j));
      tick(1);
    end
    out_ready = 1;
    send(32'hD005, 5'd13, 1, 0, 0, 0, 0, 1, 0, acc);
    chk("t3_acc6", 64'(acc), 64'(c0 + 9));
    tick(12);
    chk("t3_retire", 64'(retire_cnt), 64'(4));
    chk("t3_stall_end", 64'(stall_cnt), 64'(14));
    chk("t3_occ_end", 64'(occupancy), 64'(0));
    out_ready = 0;
    for (int k = 0; k < 3; k++) send(32'hE000 + 32'(k), 5'(16 + k), 1, 0, 0, 0, 0, 0, 0, acc);
    in_valid = 1; in_data = 32'hE003; in_rd = 5'd19; flush = 1;
    @(negedge clk);
    chk("t4_in_ready", 64'(in_ready), 64'(0));
    chk("t4_occ_pre", 64'(occupancy), 64'(3));
    tick(1);
    flush = 0; in_valid = 0;
    chk("t4_occ", 64'(occupancy), 64'(0));
    chk("t4_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1;
    tick(10);
    chk("t4_retire", 64'(retire_cnt), 64'(4));
    chk("t4_stall", 64'(stall_cnt), 64'(15));
    out_ready = 0;
    for (int k = 0; k < 4; k++) send(32'hF000 + 32'(k), 5'(20 + k), 1, 0, 0, 0, 0, 0, 0, acc);
    reset = 1;
    tick(1);
    reset = 0;
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_out_data", 64'(out_data), 64'(0));
    chk("t5_out_rd", 64'(out_rd), 64'(0));
    chk("t5_out_rd_we", 64'(out_rd_we), 64'(0));
    chk("t5_occ", 64'(occupancy), 64'(0));
    chk("t5_retire", 64'(retire_cnt), 64'(0));
    chk("t5_stall", 64'(stall_cnt), 64'(0));
    out_ready = 1;
    tick(10);
    chk("t5_occ_end", 64'(occupancy), 64'(0));
    for (int k = 0; k < 17; k++) send(32'h1700 + 32'(k), 5'(k + 1), 1, 0, 0, 0, 0, 1, 1, acc);
    tick(10);
    chk("t6_retire_wrap", 64'(retire_cnt), 64'(1));
    chk("t6_stall", 64'(stall_cnt), 64'(0));
    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
